inst_fetch_resp: RTL

- Instruction-side responder for the PC register's (pc, ce) fetch request.
- Accepts the word address presented by the PC stage and performs a word read over a simple req/ack memory bus.
- Returns the instruction to the IF/ID stage.
- Asserts a stall request to the pipeline controller until the word for the current pc is available.
- Sits between the PC register, the IF/ID latch and the instruction memory bus.

---
 rtl/inst_fetch_resp.sv | 122 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: turns the PC stage's (pc, ce) into word reads on a req/ack bus, returns the word to IF/ID.
// Latency: hit = 0 extra cycles; miss = 2+k cycles (k = ack wait after req rises), stallreq_o held meanwhile.
// Backpressure: bus_req_o/bus_addr_o held until bus_ack_i; optional watchdog (IFETCH_TIMEOUT_EN) aborts after TIMEOUT cycles.
module inst_fetch_resp #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stallreq_o,
    output logic              adel_o,
    output logic              bus_err_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;
    logic              drop;
    logic              hit;
    logic              mis;
    logic              start;

    // One-entry buffer lookup and pipeline-facing outputs.
    assign hit          = buf_valid && (buf_addr == pc_i);
    assign mis          = (pc_i[1:0] != 2'b00);
    assign inst_valid_o = ce_i & hit & ~mis;
    assign inst_o       = inst_valid_o ? buf_data : '0;
    assign stallreq_o   = ce_i & ~hit & ~mis & ~flush_i;
    assign adel_o       = ce_i & mis;

    // A new fetch starts exactly when the pipeline is being stalled for a word we lack.
    assign start = stallreq_o;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // Comparing the pre-increment value means the abort lands on the cycle the count would reach TIMEOUT.
    assign timeout_hit = (state == S_BUSY) && !bus_ack_i && (cnt == CNT_W'(TIMEOUT - 1));
`else
    // No watchdog in this build: a request waits for its ack forever and never errors.
    assign bus_err_o = (TIMEOUT < 0);
`endif

    // FSM, bus request register and fetch buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            bus_req_o  <= 1'b0;
            bus_addr_o <= '0;
            buf_addr   <= '0;
            buf_data   <= '0;
            buf_valid  <= 1'b0;
            drop       <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            cnt        <= '0;
            bus_err_o  <= 1'b0;
`endif
        end else begin
`ifdef IFETCH_TIMEOUT_EN
            bus_err_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_BUSY;
                        bus_req_o  <= 1'b1;
                        bus_addr_o <= pc_i;
                        drop       <= 1'b0;
                    end
                end
                default: begin
                    // A flushed transaction still runs to its ack; only its data is thrown away.
                    if (flush_i) begin
                        drop <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        if (!drop && !flush_i) begin
                            buf_data  <= bus_rdata_i;
                            buf_addr  <= bus_addr_o;
                            buf_valid <= 1'b1;
                        end
                        bus_req_o <= 1'b0;
                        state     <= S_IDLE;
`ifdef IFETCH_TIMEOUT_EN
                        cnt       <= '0;
                    end else if (timeout_hit) begin
                        bus_req_o <= 1'b0;
                        state     <= S_IDLE;
                        buf_valid <= 1'b0;
                        bus_err_o <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
            endcase
            // Flush invalidates the buffer regardless of state, overriding any load this cycle.
            if (flush_i) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule
